// File: rtl/ct_ifu_sfp_pkg.sv
// Shared definitions for the IFU store-forward-predictor (SFP) table.
//   SFP_OP_*      : bit positions of the one-hot counter op on entry_write_op
//   sfp_sat_inc() : increment that saturates at 2^width-1
//   sfp_sat_dec() : decrement that saturates at 0
package ct_ifu_sfp_pkg;

  localparam int unsigned SFP_OP_W    = 4;
  localparam int unsigned SFP_OP_CLR  = 3;
  localparam int unsigned SFP_OP_HIT  = 2;
  localparam int unsigned SFP_OP_INIT = 1;
  localparam int unsigned SFP_OP_MISS = 0;

  function automatic logic [31:0] sfp_sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : val + 32'd1;
  endfunction

  function automatic logic [31:0] sfp_sat_dec(input logic [31:0] val, input int unsigned width);
    // width is kept for symmetry with sfp_sat_inc; the floor is always 0
    logic [31:0] unused_w;
    unused_w = 32'(width);
    return (val == 32'd0) ? 32'd0 : val - 32'd1;
  endfunction

endpackage

// File: rtl/ct_ifu_sfp_sat_cnt.sv
// Saturating up/down counter with load and clear.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : clear to 0 (highest priority)
//   load_i       : load load_val_i
//   dec_i/inc_i  : saturating step down/up (dec wins over inc)
//   cnt_o        : current count
module ct_ifu_sfp_sat_cnt
  import ct_ifu_sfp_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (dec_i)  cnt_d = WIDTH'(sfp_sat_dec(32'(cnt_q), WIDTH));
    else if (inc_i)  cnt_d = WIDTH'(sfp_sat_inc(32'(cnt_q), WIDTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate.
//   clk_in             : free-running clock
//   global_en          : global clock enable
//   module_en          : module-level force-on
//   local_en           : local enable request
//   external_en        : external force-on
//   pad_yy_icg_scan_en : scan bypass
//   clk_out            : gated clock
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch;
  logic clk_en_af_latch;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Enable is captured while the clock is low so clk_out never glitches.
  always_latch begin
    if (!clk_in) clk_en_af_latch <= clk_en_bf_latch;
  end

  assign clk_out = clk_in & (clk_en_af_latch | pad_yy_icg_scan_en);

endmodule

// File: rtl/ct_ifu_sfp_entry_mb.sv
// One SFP table entry: predicted store PC (+hi bits, type), BAR_NUM barrier PCs with
// dedupe and round-robin replacement, a saturating confidence counter with idle aging,
// and combinational hit vectors against a lookup PC.
//   write side : entry_write_en_x, *_updt_bit, entry_write_{type,hi_pc,pc,op}, miss hint
//   control    : entry_flush, entry_age_tick, rtu_ifu_chgflw_vld, ICG/predictor enables
//   state out  : entry_vld_v, PCs, type, barrier PCs/valids, counter, confidence
//   lookup     : lookup_{hi_pc,pc} -> entry_sf_hit, entry_bar_hit (zero latency)
module ct_ifu_sfp_entry_mb
  import ct_ifu_sfp_pkg::*;
#(
  parameter int unsigned HI_W    = 8,
  parameter int unsigned PC_W    = 12,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned CONF_TH = 2,
  parameter int unsigned BAR_NUM = 2,
  parameter int unsigned AGE_W   = 4
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  input  logic                    cp0_yy_clk_en,
  input  logic                    cp0_ifu_icg_en,
  input  logic                    pad_yy_icg_scan_en,
  input  logic                    cp0_ifu_nsfe,
  input  logic                    sfp_vl_pred_en,
  input  logic                    entry_clk_en_x,
  input  logic                    entry_write_en_x,
  input  logic                    entry_sf_pc_updt_bit,
  input  logic                    entry_bar_pc_updt_bit,
  input  logic                    entry_cnt_updt_bit,
  input  logic                    entry_write_type,
  input  logic [HI_W-1:0]         entry_write_hi_pc,
  input  logic [PC_W-1:0]         entry_write_pc,
  input  logic [SFP_OP_W-1:0]     entry_write_op,
  input  logic                    entry_miss_hint,
  input  logic                    rtu_ifu_chgflw_vld,
  input  logic                    entry_age_tick,
  input  logic                    entry_flush,
  input  logic [HI_W-1:0]         lookup_hi_pc,
  input  logic [PC_W-1:0]         lookup_pc,
  output logic                    entry_vld_v,
  output logic [HI_W-1:0]         entry_hi_pc_v,
  output logic [PC_W-1:0]         entry_sf_pc_v,
  output logic                    entry_type_x,
  output logic [BAR_NUM*PC_W-1:0] entry_bar_pc_v,
  output logic [BAR_NUM-1:0]      entry_bar_vld_v,
  output logic [CNT_W-1:0]        entry_cnt_v,
  output logic                    entry_conf_v,
  output logic                    entry_sf_hit,
  output logic [BAR_NUM-1:0]      entry_bar_hit
);

  localparam int unsigned VicW = (BAR_NUM > 1) ? $clog2(BAR_NUM) : 1;
  // Age value whose next tick would reach 2^AGE_W-1, i.e. the wrap point.
  localparam logic [AGE_W-1:0] AgeLast = AGE_W'((1 << AGE_W) - 2);
  localparam logic [SFP_OP_W-1:0] OpClr  = 4'b0001 << SFP_OP_CLR;
  localparam logic [SFP_OP_W-1:0] OpHit  = 4'b0001 << SFP_OP_HIT;
  localparam logic [SFP_OP_W-1:0] OpInit = 4'b0001 << SFP_OP_INIT;
  localparam logic [SFP_OP_W-1:0] OpMiss = 4'b0001 << SFP_OP_MISS;

  logic pred_en, wq, local_en, entry_clk;
  logic sf_wr, bar_wr, cnt_wr, age_step, age_wrap;

  logic                          vld_q, type_q, miss_q;
  logic [HI_W-1:0]               hi_pc_q;
  logic [PC_W-1:0]               sf_pc_q;
  logic [BAR_NUM-1:0][PC_W-1:0]  bar_pc_q;
  logic [BAR_NUM-1:0]            bar_vld_q;
  logic [VicW-1:0]               victim_q;
  logic [CNT_W-1:0]              cnt_q, cnt_op_val;
  logic [AGE_W-1:0]              age_q;

  logic            bar_dup, free_found;
  logic [VicW-1:0] free_idx, bar_idx, victim_nxt;

  assign pred_en  = cp0_ifu_nsfe | sfp_vl_pred_en;
  assign wq       = entry_write_en_x & pred_en;
  assign local_en = (entry_clk_en_x & pred_en) | entry_flush | entry_age_tick;

  gated_clk_cell u_entry_gclk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_ifu_icg_en),
    .local_en           (local_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (entry_clk)
  );

  // Flush drops every write; an SF write also drops a same-cycle barrier write.
  assign sf_wr    = wq & entry_sf_pc_updt_bit & ~entry_flush;
  assign bar_wr   = wq & entry_bar_pc_updt_bit & ~entry_sf_pc_updt_bit & ~entry_flush;
  assign cnt_wr   = wq & entry_cnt_updt_bit & ~entry_flush;
  assign age_step = entry_age_tick & vld_q & ~cnt_wr & ~entry_flush;
  assign age_wrap = age_step & (age_q == AgeLast);

  // Counter op result; uses pre-update type/miss state.
  always_comb begin
    cnt_op_val = '0;
    case (entry_write_op)
      OpClr:  cnt_op_val = '0;
      OpHit:  cnt_op_val = (type_q && cnt_q == CNT_W'(1)) ? '0
                           : CNT_W'(sfp_sat_inc(32'(cnt_q), CNT_W));
      OpInit: cnt_op_val = CNT_W'(1);
      OpMiss: cnt_op_val = (miss_q && rtu_ifu_chgflw_vld)
                           ? CNT_W'(sfp_sat_inc(32'(cnt_q), CNT_W))
                           : CNT_W'(sfp_sat_dec(32'(cnt_q), CNT_W));
      default: cnt_op_val = '0;
    endcase
  end

  ct_ifu_sfp_sat_cnt #(.WIDTH(CNT_W)) u_cnt (
    .clk_i      (entry_clk),
    .rst_i      (cpurst),
    .clr_i      (entry_flush),
    .load_i     (cnt_wr),
    .load_val_i (cnt_op_val),
    .inc_i      (1'b0),
    .dec_i      (age_wrap),
    .cnt_o      (cnt_q)
  );

  ct_ifu_sfp_sat_cnt #(.WIDTH(AGE_W)) u_age (
    .clk_i      (entry_clk),
    .rst_i      (cpurst),
    .clr_i      (entry_flush | cnt_wr | age_wrap),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (age_step),
    .dec_i      (1'b0),
    .cnt_o      (age_q)
  );

  // Barrier slot selection: dedupe, then lowest free slot, then round-robin victim.
  always_comb begin
    bar_dup    = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < BAR_NUM; i++) begin
      if (bar_vld_q[i] && bar_pc_q[i] == entry_write_pc) bar_dup = 1'b1;
      if (!bar_vld_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = VicW'(i);
      end
    end
    bar_idx    = free_found ? free_idx : victim_q;
    victim_nxt = (victim_q == VicW'(BAR_NUM - 1)) ? '0 : victim_q + VicW'(1);
  end

  always_ff @(posedge entry_clk or posedge cpurst) begin
    if (cpurst) begin
      vld_q     <= 1'b0;
      type_q    <= 1'b0;
      miss_q    <= 1'b0;
      hi_pc_q   <= '0;
      sf_pc_q   <= '0;
      bar_pc_q  <= '0;
      bar_vld_q <= '0;
      victim_q  <= '0;
    end else if (entry_flush) begin
      vld_q     <= 1'b0;
      miss_q    <= 1'b0;
      bar_vld_q <= '0;
    end else if (sf_wr) begin
      vld_q     <= 1'b1;
      type_q    <= entry_write_type;
      miss_q    <= entry_write_type & entry_miss_hint;
      hi_pc_q   <= entry_write_hi_pc;
      sf_pc_q   <= entry_write_pc;
      bar_vld_q <= '0;
    end else if (bar_wr && !bar_dup) begin
      bar_pc_q[bar_idx]  <= entry_write_pc;
      bar_vld_q[bar_idx] <= 1'b1;
      if (!free_found) victim_q <= victim_nxt;
    end
  end

  always_comb begin
    entry_bar_hit = '0;
    for (int i = 0; i < BAR_NUM; i++) begin
      entry_bar_hit[i] = bar_vld_q[i] & (bar_pc_q[i] == lookup_pc);
    end
  end

  assign entry_sf_hit    = vld_q & (hi_pc_q == lookup_hi_pc) & (sf_pc_q == lookup_pc);
  assign entry_vld_v     = vld_q;
  assign entry_hi_pc_v   = hi_pc_q;
  assign entry_sf_pc_v   = sf_pc_q;
  assign entry_type_x    = type_q;
  assign entry_bar_pc_v  = bar_pc_q;
  assign entry_bar_vld_v = bar_vld_q;
  assign entry_cnt_v     = cnt_q;
  assign entry_conf_v    = vld_q & (cnt_q >= CNT_W'(CONF_TH));

endmodule
